// File: rtl/bellatrix_clint_pkg.sv
// bellatrix_clint_pkg: CLINT register offsets, reset values, bus FSM states and byte-merge helper
package bellatrix_clint_pkg;
  localparam logic [31:0] CLINT_MSIP        = 32'h00;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h08;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0C;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'h10;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'h14;
  localparam logic [63:0] MTIMECMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef enum logic [1:0] {WB_IDLE, WB_ACK, WB_ERR} wb_state_t;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? dat[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/bellatrix_clint_tick.sv
// bellatrix_clint_tick: free-running prescaler emitting one tick every TICK_DIV cycles
module bellatrix_clint_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [31:0] cnt;
  assign tick = cnt == 32'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 32'd1;
  end
endmodule

// File: rtl/bellatrix_clint.sv
// bellatrix_clint: Wishbone classic core-local interruptor with mtime, mtimecmp and msip
module bellatrix_clint
  import bellatrix_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          WIN_WIDTH = 5,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_addr,
  input  logic [31:0] wbs_dat_w,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  input  logic [2:0]  wbs_cti,
  input  logic [1:0]  wbs_bte,
  output logic [31:0] wbs_dat_r,
  output logic        wbs_ack,
  output logic        wbs_err,
  output logic        timer_interrupt,
  output logic        software_interrupt
);
  wb_state_t   state, state_nxt;
  logic [63:0] mtime, mtimecmp, mtime_inc, mtime_nxt, mtimecmp_nxt;
  logic [31:0] off, rdata;
  logic        tick, hit, mapped, req, wr, msip, msip_nxt, unused;
  bellatrix_clint_tick #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign unused    = ^{wbs_cti, wbs_bte};
  assign off       = {{(32 - WIN_WIDTH){1'b0}}, wbs_addr[WIN_WIDTH-1:0]};
  assign hit       = wbs_addr[31:WIN_WIDTH] == BASE_ADDR[31:WIN_WIDTH];
  assign mapped    = off inside {CLINT_MSIP, CLINT_MTIMECMP_LO, CLINT_MTIMECMP_HI, CLINT_MTIME_LO, CLINT_MTIME_HI};
  assign wbs_ack   = state == WB_ACK;
  assign wbs_err   = state == WB_ERR;
  assign req       = wbs_cyc & wbs_stb & hit & ~(wbs_ack | wbs_err);
  assign wr        = req & wbs_we & mapped;
  assign mtime_inc = mtime + {63'd0, tick};
  always_comb begin
    state_nxt    = req ? (mapped ? WB_ACK : WB_ERR) : WB_IDLE;
    rdata        = off == CLINT_MSIP        ? {31'd0, msip}    :
                   off == CLINT_MTIMECMP_LO ? mtimecmp[31:0]   :
                   off == CLINT_MTIMECMP_HI ? mtimecmp[63:32]  :
                   off == CLINT_MTIME_LO    ? mtime[31:0]      :
                   off == CLINT_MTIME_HI    ? mtime[63:32]     : 32'd0;
    msip_nxt     = (wr && off == CLINT_MSIP && wbs_sel[0]) ? wbs_dat_w[0] : msip;
    mtime_nxt    = {(wr && off == CLINT_MTIME_HI) ? merge_bytes(mtime_inc[63:32], wbs_dat_w, wbs_sel) : mtime_inc[63:32],
                    (wr && off == CLINT_MTIME_LO) ? merge_bytes(mtime_inc[31:0], wbs_dat_w, wbs_sel) : mtime_inc[31:0]};
    mtimecmp_nxt = {(wr && off == CLINT_MTIMECMP_HI) ? merge_bytes(mtimecmp[63:32], wbs_dat_w, wbs_sel) : mtimecmp[63:32],
                    (wr && off == CLINT_MTIMECMP_LO) ? merge_bytes(mtimecmp[31:0], wbs_dat_w, wbs_sel) : mtimecmp[31:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WB_IDLE;
      wbs_dat_r          <= '0;
      mtime              <= '0;
      mtimecmp           <= MTIMECMP_RST;
      msip               <= 1'b0;
      timer_interrupt    <= 1'b0;
      software_interrupt <= 1'b0;
    end else begin
      state              <= state_nxt;
      wbs_dat_r          <= (req & mapped & ~wbs_we) ? rdata : '0;
      mtime              <= mtime_nxt;
      mtimecmp           <= mtimecmp_nxt;
      msip               <= msip_nxt;
      timer_interrupt    <= mtime >= mtimecmp;
      software_interrupt <= msip;
    end
  end
endmodule

// File: tb/tb_bellatrix_clint.sv
// tb_bellatrix_clint: directed scoreboard bench for bellatrix_clint at TICK_DIV 1 and 4
module tb_bellatrix_clint;
  localparam logic [31:0] B = 32'h0200_0000;
  typedef struct {string tag; logic err; logic [31:0] lo; logic [31:0] hi;} exp_t;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0, dat_w = 0;
  logic [3:0] sel = 0;
  logic cyc = 0, stb = 0, we = 0;
  logic [2:0] cti = 0;
  logic [1:0] bte = 0;
  logic [31:0] dat_r1, dat_r4, rd4;
  logic ack1, err1, ti1, si1, ack4, err4, ti4, si4;
  logic prev_resp = 0, seen;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, ph = 0, n;
  always #5 clk = ~clk;
  bellatrix_clint #(.TICK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .wbs_addr(addr), .wbs_dat_w(dat_w), .wbs_sel(sel), .wbs_cyc(cyc),
    .wbs_stb(stb), .wbs_we(we), .wbs_cti(cti), .wbs_bte(bte), .wbs_dat_r(dat_r1), .wbs_ack(ack1),
    .wbs_err(err1), .timer_interrupt(ti1), .software_interrupt(si1));
  bellatrix_clint #(.TICK_DIV(4)) u4 (
    .clk(clk), .rst(rst), .wbs_addr(addr), .wbs_dat_w(dat_w), .wbs_sel(sel), .wbs_cyc(cyc),
    .wbs_stb(stb), .wbs_we(we), .wbs_cti(cti), .wbs_bte(bte), .wbs_dat_r(dat_r4), .wbs_ack(ack4),
    .wbs_err(err4), .timer_interrupt(ti4), .software_interrupt(si4));
  always @(posedge clk) ph <= rst ? 0 : (ph == 3 ? 0 : ph + 1);
  always @(negedge clk) begin
    if (ack1 | err1) begin
      checks++;
      assert (prev_resp === 1'b0) else begin errors++; $error("FAIL resp_width: response held ack=%b err=%b, expected one-cycle pulse", ack1, err1); end
      checks++;
      assert (q.size() != 0) else begin errors++; $error("FAIL unexpected_resp: ack=%b err=%b dat=%h, expected no response", ack1, err1, dat_r1); end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (ack1 === !e.err && err1 === e.err && dat_r1 >= e.lo && dat_r1 <= e.hi) else begin
          errors++;
          $error("FAIL %s: ack=%b err=%b dat=%h, expected err=%b dat in [%h,%h]", e.tag, ack1, err1, dat_r1, e.err, e.lo, e.hi);
        end
      end
    end
    prev_resp = ack1 | err1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s: got %h expected %h", tag, got, exp); end
  endtask
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    addr = a; we = w; dat_w = d; sel = s; cyc = 1; stb = 1;
    do begin @(posedge clk); #1; k++; end while (!(ack1 | err1) && k < 20);
    chk("bus_timeout", {63'd0, ack1 | err1}, 64'd1);
    rd4 = dat_r4;
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    q.push_back('{tag, 1'b0, lo, hi});
    bus(a, 1'b0, 32'd0, 4'hF);
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    q.push_back('{tag, 1'b0, 32'd0, 32'hFFFF_FFFF});
    bus(a, 1'b1, d, s);
  endtask
  task automatic unm(input string tag, input logic [31:0] a, input logic w);
    q.push_back('{tag, 1'b1, 32'd0, 32'd0});
    bus(a, w, 32'd0, 4'hF);
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ack", {63'd0, ack1}, 0);
    chk("rst_err", {63'd0, err1}, 0);
    chk("rst_dat", {32'd0, dat_r1}, 0);
    chk("rst_ti", {63'd0, ti1}, 0);
    chk("rst_si", {63'd0, si1}, 0);
    chk("rst_ti4", {63'd0, ti4}, 0);
    repeat (10) step();
    rd("mtime_idle10", B + 32'h10, 32'd8, 32'd12);
    chk("idle_ti", {63'd0, ti1}, 0);
    chk("idle_si", {63'd0, si1}, 0);
    step();
    chk("dat_idle", {32'd0, dat_r1}, 0);
    repeat (28) step();
    rd("mtime_40", B + 32'h10, 32'd40, 32'd40);
    chk("mtime_div4_40", {32'd0, rd4}, 64'd10);
    wr("msip_set", B, 32'h1, 4'hF);
    chk("si_ack_cycle", {63'd0, si1}, 0);
    step();
    chk("si_rise", {63'd0, si1}, 1);
    wr("msip_clr", B, 32'h0, 4'hF);
    chk("si_clr_ack_cycle", {63'd0, si1}, 1);
    step();
    chk("si_fall", {63'd0, si1}, 0);
    wr("msip_all", B, 32'hFFFF_FFFF, 4'hF);
    rd("msip_rd", B, 32'h1, 32'h1);
    wr("cmp_hi", B + 32'h0C, 32'h0, 4'hF);
    wr("mtime_hi0", B + 32'h14, 32'h0, 4'hF);
    wr("mtime_lo0", B + 32'h10, 32'h0, 4'hF);
    wr("cmp_lo20", B + 32'h08, 32'h20, 4'hF);
    chk("ti_before", {63'd0, ti1}, 0);
    n = 0;
    while (!ti1 && n < 100) begin step(); n++; end
    chk("ti_rise_cycle", n, 31);
    wr("cmp_lo_max", B + 32'h08, 32'hFFFF_FFFF, 4'hF);
    chk("ti_ack_cycle", {63'd0, ti1}, 1);
    step();
    chk("ti_fall", {63'd0, ti1}, 0);
    wr("mtime_hi_c", B + 32'h14, 32'h0, 4'hF);
    wr("mtime_lo_c", B + 32'h10, 32'hFFFF_FFFE, 4'hF);
    step();
    step();
    rd("carry_hi", B + 32'h14, 32'h1, 32'h1);
    rd("carry_lo", B + 32'h10, 32'h2, 32'h2);
    wr("lo_full", B + 32'h10, 32'h1234_5600, 4'hF);
    wr("lo_byte0", B + 32'h10, 32'h0000_00AB, 4'b0001);
    rd("byte_lo", B + 32'h10, 32'h1234_56AC, 32'h1234_56AC);
    do step(); while (ph != 3);
    wr("tick_wr", B + 32'h10, 32'h100, 4'hF);
    rd("tick_wr_u1", B + 32'h10, 32'h101, 32'h101);
    chk("tick_wr_u4", {32'd0, rd4}, 64'h100);
    unm("unmapped_rd", B + 32'h04, 1'b0);
    unm("unmapped_wr", B + 32'h04, 1'b1);
    rd("msip_after_unm", B, 32'h1, 32'h1);
    addr = B + 32'h20; we = 0; cyc = 1; stb = 1; seen = 0;
    repeat (5) begin step(); seen |= ack1 | err1; end
    cyc = 0; stb = 0;
    chk("nonhit_silent", {63'd0, seen}, 0);
    addr = B + 32'h08; we = 0; cyc = 1; stb = 1; rst = 1;
    step();
    chk("rst_mid_ack", {63'd0, ack1}, 0);
    chk("rst_mid_err", {63'd0, err1}, 0);
    cyc = 0; stb = 0;
    step();
    rst = 0;
    chk("rst_mid_si", {63'd0, si1}, 0);
    rd("cmp_lo_rst", B + 32'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("cmp_hi_rst", B + 32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
